// File: rtl/nonlin_cube_deriv_array.sv
// nonlin_cube_deriv_array
//   NUM_CH-lane, 3-stage pipelined nonlinearity for FastICA. Per lane it produces
//   g(x) = x^3 and g'(x) = 3x^2 in signed fixed point (FRAC_WIDTH fraction bits),
//   rounded half-up and saturated to DATA_WIDTH. A per-lane unsigned accumulator sums
//   the delivered g'(x) values together with a sample counter.
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     input handshake; in_data lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready   output handshake; out_cube, out_deriv, out_sat per lane
//   acc_clr               clear accumulators/counter (clear-then-add with a handshake)
//   deriv_acc, acc_cnt    per-lane running sum of out_deriv, number of samples summed
module nonlin_cube_deriv_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = 10,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_cube,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_deriv,
  output logic [NUM_CH-1:0]            out_sat,
  input  logic                         acc_clr,
  output logic [NUM_CH*ACC_WIDTH-1:0]  deriv_acc,
  output logic [CNT_WIDTH-1:0]         acc_cnt
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = 3 * W + 1;  // cube path: room for the rounding add
  localparam int unsigned DW = 2 * W + 2;  // deriv path: 3*sq plus rounding add

  localparam logic signed [CW-1:0] CubeHalf = CW'(1) <<< (2 * FRAC_WIDTH - 1);
  localparam logic signed [CW-1:0] CubeMax  = (CW'(1) <<< (W - 1)) - CW'(1);
  localparam logic signed [CW-1:0] CubeMin  = -(CW'(1) <<< (W - 1));
  localparam logic signed [DW-1:0] DerHalf  = DW'(1) <<< (FRAC_WIDTH - 1);
  localparam logic signed [DW-1:0] DerMax   = (DW'(1) <<< (W - 1)) - DW'(1);
  localparam logic signed [DW-1:0] DerMin   = -(DW'(1) <<< (W - 1));

  logic                  v1_q, v2_q, v3_q;
  logic signed [W-1:0]   x1_q    [NUM_CH];
  logic signed [W-1:0]   x2_q    [NUM_CH];
  logic signed [2*W-1:0] sq2_q   [NUM_CH];
  logic signed [W-1:0]   cube_q  [NUM_CH];
  logic signed [W-1:0]   deriv_q [NUM_CH];
  logic [NUM_CH-1:0]     sat_q;
  logic [ACC_WIDTH-1:0]  acc_q   [NUM_CH];
  logic [ACC_WIDTH-1:0]  acc_d   [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic signed [2*W-1:0] sq_c    [NUM_CH];
  logic signed [W-1:0]   cube_c  [NUM_CH];
  logic signed [W-1:0]   deriv_c [NUM_CH];
  logic [NUM_CH-1:0]     sat_c;

  logic en, deliver;

  // Whole pipeline advances together; it only stalls on a held, unaccepted output.
  assign en       = !v3_q | out_ready;
  assign in_ready = en & !rst;
  assign deliver  = v3_q & out_ready;

  always_comb begin
    logic signed [CW-1:0] x_ext, sq_ext, cube_full, cube_rnd;
    logic signed [DW-1:0] sq_w, deriv_full, deriv_rnd;
    x_ext      = '0;
    sq_ext     = '0;
    cube_full  = '0;
    cube_rnd   = '0;
    sq_w       = '0;
    deriv_full = '0;
    deriv_rnd  = '0;
    sat_c      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      // S2 square, computed on sign-extended operands so the product is exact.
      sq_c[k] = $signed({{W{x1_q[k][W-1]}}, x1_q[k]}) *
                $signed({{W{x1_q[k][W-1]}}, x1_q[k]});

      x_ext     = $signed({{(CW-W){x2_q[k][W-1]}}, x2_q[k]});
      sq_ext    = $signed({{(CW-2*W){sq2_q[k][2*W-1]}}, sq2_q[k]});
      cube_full = sq_ext * x_ext;
      cube_rnd  = (cube_full + CubeHalf) >>> (2 * FRAC_WIDTH);
      if (cube_rnd > CubeMax) begin
        cube_c[k] = CubeMax[W-1:0];
        sat_c[k]  = 1'b1;
      end else if (cube_rnd < CubeMin) begin
        cube_c[k] = CubeMin[W-1:0];
        sat_c[k]  = 1'b1;
      end else begin
        cube_c[k] = cube_rnd[W-1:0];
      end

      sq_w       = $signed({{2{sq2_q[k][2*W-1]}}, sq2_q[k]});
      deriv_full = sq_w + (sq_w <<< 1);
      deriv_rnd  = (deriv_full + DerHalf) >>> FRAC_WIDTH;
      if (deriv_rnd > DerMax) begin
        deriv_c[k] = DerMax[W-1:0];
        sat_c[k]   = 1'b1;
      end else if (deriv_rnd < DerMin) begin
        deriv_c[k] = DerMin[W-1:0];
        sat_c[k]   = 1'b1;
      end else begin
        deriv_c[k] = deriv_rnd[W-1:0];
      end
    end
  end

  // Accumulators: clear first, then add the delivered sample (saturating).
  always_comb begin
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] base;
    logic [CNT_WIDTH:0]   csum;
    logic [CNT_WIDTH-1:0] cbase;
    sum  = '0;
    base = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      base     = acc_clr ? '0 : acc_q[k];
      sum      = {1'b0, base} + {{(ACC_WIDTH+1-W){1'b0}}, deriv_q[k]};
      acc_d[k] = base;
      if (deliver) acc_d[k] = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    end
    cbase = acc_clr ? '0 : cnt_q;
    csum  = {1'b0, cbase} + {{CNT_WIDTH{1'b0}}, 1'b1};
    cnt_d = cbase;
    if (deliver) cnt_d = csum[CNT_WIDTH] ? '1 : csum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sat_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        x1_q[k]    <= '0;
        x2_q[k]    <= '0;
        sq2_q[k]   <= '0;
        cube_q[k]  <= '0;
        deriv_q[k] <= '0;
        acc_q[k]   <= '0;
      end
    end else begin
      if (en) begin
        v1_q  <= in_valid;
        v2_q  <= v1_q;
        v3_q  <= v2_q;
        sat_q <= sat_c;
        for (int k = 0; k < NUM_CH; k++) begin
          x1_q[k]    <= in_data[k*W +: W];
          x2_q[k]    <= x1_q[k];
          sq2_q[k]   <= sq_c[k];
          cube_q[k]  <= cube_c[k];
          deriv_q[k] <= deriv_c[k];
        end
      end
      cnt_q <= cnt_d;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign out_valid = v3_q;
  assign out_sat   = sat_q;
  assign acc_cnt   = cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    assign out_cube[k*W +: W]                  = cube_q[k];
    assign out_deriv[k*W +: W]                 = deriv_q[k];
    assign deriv_acc[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
  end

endmodule

// File: tb/tb_nonlin_cube_deriv_array.sv
// tb_nonlin_cube_deriv_array
//   Directed plus randomized bench for nonlin_cube_deriv_array (W=16, F=10, 4 lanes).
//   Expected results come from a fixed-point arithmetic model and a queue of accepted
//   samples; the accumulator model sums the model's g'(x) values.
module tb_nonlin_cube_deriv_array;
  localparam int W = 16, F = 10, N = 4, AW = 32, CNTW = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, acc_clr;
  logic [N*W-1:0]  in_data, out_cube, out_deriv;
  logic [N-1:0]    out_sat;
  logic [N*AW-1:0] deriv_acc;
  logic [CNTW-1:0] acc_cnt;

  always #5 clk = ~clk;

  nonlin_cube_deriv_array #(
    .DATA_WIDTH(W), .FRAC_WIDTH(F), .NUM_CH(N), .ACC_WIDTH(AW), .CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cube(out_cube),
    .out_deriv(out_deriv), .out_sat(out_sat), .acc_clr(acc_clr),
    .deriv_acc(deriv_acc), .acc_cnt(acc_cnt)
  );

  typedef struct packed {
    logic [N*W-1:0] cube;
    logic [N*W-1:0] deriv;
    logic [N-1:0]   sat;
  } exp_t;

  exp_t   q[$];
  longint m_acc[N];
  longint m_cnt;
  int     n_cmp = 0, n_err = 0, n_deliv = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [N*W-1:0] d);
    exp_t   e;
    longint x, sq, c, dv, lim;
    logic   s;
    lim = longint'(1) << (W - 1);
    for (int k = 0; k < N; k++) begin
      x  = longint'($signed(d[k*W +: W]));
      sq = x * x;
      c  = (sq * x + (longint'(1) << (2 * F - 1))) >>> (2 * F);
      dv = (3 * sq + (longint'(1) << (F - 1))) >>> F;
      s  = 1'b0;
      if (c > lim - 1) begin c = lim - 1; s = 1'b1; end
      if (c < -lim) begin c = -lim; s = 1'b1; end
      if (dv > lim - 1) begin dv = lim - 1; s = 1'b1; end
      e.cube[k*W +: W]  = c[W-1:0];
      e.deriv[k*W +: W] = dv[W-1:0];
      e.sat[k]          = s;
    end
    return e;
  endfunction

  function automatic logic [N*W-1:0] pack4(input int a0, input int a1, input int a2,
                                           input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] r;
    int ev[6];
    ev = '{0, 1, -1, 32767, -32768, 1024};
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(3) == 0) r[k*W +: W] = W'(ev[$urandom_range(5)]);
      else r[k*W +: W] = W'($urandom);
    end
    return r;
  endfunction

  // One clock: drive, sample at mid-cycle, score handshakes, advance past the edge.
  task automatic cycle(input logic iv, input logic [N*W-1:0] dat, input logic ordy,
                       input logic clr, output logic acc_o, output logic dlv_o);
    exp_t e;
    in_valid = iv; in_data = dat; out_ready = ordy; acc_clr = clr;
    #1;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    for (int k = 0; k < N; k++)
      check($sformatf("deriv_acc%0d", k), deriv_acc[k*AW +: AW], m_acc[k]);
    check("acc_cnt", acc_cnt, m_cnt);
    acc_o = in_valid && in_ready;
    dlv_o = out_valid && out_ready;
    if (clr) begin
      for (int k = 0; k < N; k++) m_acc[k] = 0;
      m_cnt = 0;
    end
    if (dlv_o) begin
      n_deliv++;
      if (q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        for (int k = 0; k < N; k++) begin
          check($sformatf("cube%0d", k), $signed(out_cube[k*W +: W]),
                $signed(e.cube[k*W +: W]));
          check($sformatf("deriv%0d", k), $signed(out_deriv[k*W +: W]),
                $signed(e.deriv[k*W +: W]));
          m_acc[k] += longint'(e.deriv[k*W +: W]);
          if (m_acc[k] > 64'hFFFF_FFFF) m_acc[k] = 64'hFFFF_FFFF;
        end
        check("sat", out_sat, e.sat);
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (acc_o) q.push_back(model(dat));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cube", out_cube, 0);
    check("rst_deriv", out_deriv, 0);
    check("rst_sat", out_sat, 0);
    check("rst_cnt", acc_cnt, 0);
    for (int k = 0; k < N; k++)
      check($sformatf("rst_acc%0d", k), deriv_acc[k*AW +: AW], 0);
    rst = 1'b0;
    q.delete();
    for (int k = 0; k < N; k++) m_acc[k] = 0;
    m_cnt = 0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic check_vec(input string tag, input logic [N*W-1:0] ec,
                           input logic [N*W-1:0] ed, input logic [N-1:0] es);
    check({tag, "_valid"}, out_valid, 1);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_cube%0d", tag, k), $signed(out_cube[k*W +: W]),
            $signed(ec[k*W +: W]));
      check($sformatf("%s_deriv%0d", tag, k), $signed(out_deriv[k*W +: W]),
            $signed(ed[k*W +: W]));
    end
    check({tag, "_sat"}, out_sat, es);
  endtask

  // Send one vector on an empty pipe, wait for it, check constants, then deliver it.
  task automatic send_expect(input string tag, input logic [N*W-1:0] d,
                             input logic [N*W-1:0] ec, input logic [N*W-1:0] ed,
                             input logic [N-1:0] es);
    logic a, v;
    int lat;
    cycle(1'b1, d, 1'b1, 1'b0, a, v);
    check({tag, "_accepted"}, a, 1);
    lat = 0;
    while (!out_valid && lat < 8) begin
      cycle(1'b0, '0, 1'b1, 1'b0, a, v);
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check_vec(tag, ec, ed, es);
    cycle(1'b0, '0, 1'b1, 1'b0, a, v);
  endtask

  logic [N*W-1:0] vecs[20];
  logic [N*W-1:0] one_v;
  logic a, v, saw_stall;
  int idx, start_deliv, guard;

  initial begin
    one_v = pack4(1024, 1024, 1024, 1024);
    do_reset();

    send_expect("one", one_v, one_v, pack4(3072, 3072, 3072, 3072), 4'b0000);
    send_expect("mix", pack4(2048, -2048, 512, 1), pack4(8192, -8192, 128, 0),
                pack4(12288, 12288, 768, 0), 4'b0000);
    send_expect("satur", pack4(4096, -32768, 1024, 0), pack4(32767, -32768, 1024, 0),
                pack4(32767, 32767, 3072, 0), 4'b0011);

    // Streaming with a downstream stall window.
    for (int i = 0; i < 20; i++) vecs[i] = rand_vec();
    idx = 0; saw_stall = 1'b0; start_deliv = n_deliv;
    for (int c = 0; c < 100 && (idx < 20 || q.size() > 0); c++) begin
      cycle(idx < 20, (idx < 20) ? vecs[idx % 20] : '0, !(c >= 5 && c <= 9), 1'b0, a, v);
      if (idx < 20 && !a) saw_stall = 1'b1;
      if (a) idx++;
    end
    check("stream_accepted", idx, 20);
    check("stream_delivered", n_deliv - start_deliv, 20);
    check("stream_stalled", saw_stall, 1);

    // Accumulator: 10 samples, then clear-then-add, then clear alone.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, one_v, 1'b1, 1'b0, a, v);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      cycle(1'b0, '0, 1'b1, 1'b0, a, v);
      guard++;
    end
    for (int k = 0; k < N; k++)
      check($sformatf("acc10_lane%0d", k), deriv_acc[k*AW +: AW], 30720);
    check("acc10_cnt", acc_cnt, 10);
    cycle(1'b1, one_v, 1'b1, 1'b0, a, v);
    guard = 0;
    while (!out_valid && guard < 8) begin
      cycle(1'b0, '0, 1'b1, 1'b0, a, v);
      guard++;
    end
    cycle(1'b0, '0, 1'b1, 1'b1, a, v);
    check("clr_add_delivered", v, 1);
    for (int k = 0; k < N; k++)
      check($sformatf("clradd_lane%0d", k), deriv_acc[k*AW +: AW], 3072);
    check("clradd_cnt", acc_cnt, 1);
    cycle(1'b0, '0, 1'b1, 1'b1, a, v);
    for (int k = 0; k < N; k++)
      check($sformatf("clr_lane%0d", k), deriv_acc[k*AW +: AW], 0);
    check("clr_cnt", acc_cnt, 0);

    // Reset with three vectors in flight; nothing may reappear afterwards.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_vec(), 1'b1, 1'b0, a, v);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, a, v);
      check("post_rst_quiet", out_valid, 0);
    end

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, rand_vec(), $urandom_range(2) != 0,
            $urandom_range(15) == 0, a, v);
    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      cycle(1'b0, '0, 1'b1, 1'b0, a, v);
      guard++;
    end
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
